// File: rtl/az_acquisition_sequencer.sv
// Run controller for the precharge / auto-zero acquisition path: steps the PC switch
// and AZ mux through hi/lo sample pairs and handshakes one ADC conversion per phase.
module az_acquisition_sequencer #(
  parameter int CNT_W       = 32,
  parameter int PC_W        = 24,
  parameter int IDX_W       = 16,
  parameter int ADC_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W-1:0]  p_clk_count_precharge,
  input  logic [CNT_W-1:0] p_clk_sample_duration,
  input  logic [IDX_W-1:0] p_sample_count,
  input  logic [3:0]       azmux_lo_val,
  input  logic [3:0]       azmux_hi_val,
  input  logic             adc_done,
  output logic             sw_pc_ctl,
  output logic [3:0]       azmux,
  output logic             adc_start,
  output logic             adc_phase_hi,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] sample_idx,
  output logic [7:0]       monitor
);

  localparam int TO_W  = $clog2(ADC_TIMEOUT + 1);
  localparam int CTR_A = (CNT_W > PC_W) ? CNT_W : PC_W;
  localparam int CTR_W = (CTR_A > TO_W) ? CTR_A : TO_W;
  localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
  localparam logic [CTR_W-1:0] TO_LOAD  = CTR_W'(ADC_TIMEOUT - 32'sd1);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_PC_BOOT    = 4'd1,
    ST_HI_SETTLE  = 4'd2,
    ST_HI_SAMPLE  = 4'd3,
    ST_HI_CONV    = 4'd4,
    ST_PC_RESTORE = 4'd5,
    ST_LO_SAMPLE  = 4'd6,
    ST_LO_CONV    = 4'd7,
    ST_NEXT       = 4'd8,
    ST_DONE       = 4'd9
  } state_t;

  // A phase of N clks loads N-1 and leaves when the counter reads zero; N=0 behaves as 1.
  function automatic logic [CTR_W-1:0] phase_load(input logic [CTR_W-1:0] n);
    return (n == CTR_ZERO) ? CTR_ZERO : (n - CTR_ONE);
  endfunction

  state_t           state_r, state_s;
  logic [CTR_W-1:0] cnt_r, cnt_s;
  logic [PC_W-1:0]  pc_r;
  logic [CNT_W-1:0] dur_r;
  logic [IDX_W-1:0] count_r;
  logic [3:0]       lo_r, hi_r;

  logic             sw_pc_r, adc_start_r, phase_hi_r, busy_r, done_r, error_r;
  logic [3:0]       azmux_r;
  logic [IDX_W-1:0] sample_idx_r;
  logic [7:0]       monitor_r;

  logic             sw_s, azhi_s, wait_s, busy_s, done_s, adc_start_s, phase_hi_s, error_s;
  logic [3:0]       azmux_s;
  logic [IDX_W-1:0] idx_s, idx_inc_s;
  logic             accept_s, cnt_zero_s, conv_ok_s, in_conv_s, timeout_s, last_pair_s;

  assign accept_s    = (state_r == ST_IDLE) && start && !abort;
  assign cnt_zero_s  = (cnt_r == CTR_ZERO);
  // adc_done coinciding with our own adc_start belongs to no conversion of ours
  assign conv_ok_s   = adc_done && !adc_start_r;
  assign in_conv_s   = (state_r == ST_HI_CONV) || (state_r == ST_LO_CONV);
  assign timeout_s   = in_conv_s && !conv_ok_s && cnt_zero_s && !abort;
  assign idx_inc_s   = sample_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
  assign last_pair_s = (count_r != {IDX_W{1'b0}}) && (idx_inc_s == count_r);

  // State and phase counter register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CTR_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    if (abort && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:       state_s = accept_s   ? ST_PC_BOOT    : ST_IDLE;
        ST_PC_BOOT:    state_s = cnt_zero_s ? ST_HI_SETTLE  : ST_PC_BOOT;
        ST_HI_SETTLE:  state_s = cnt_zero_s ? ST_HI_SAMPLE  : ST_HI_SETTLE;
        ST_HI_SAMPLE:  state_s = cnt_zero_s ? ST_HI_CONV    : ST_HI_SAMPLE;
        ST_HI_CONV:    state_s = conv_ok_s ? ST_PC_RESTORE : (cnt_zero_s ? ST_IDLE : ST_HI_CONV);
        ST_PC_RESTORE: state_s = cnt_zero_s ? ST_LO_SAMPLE  : ST_PC_RESTORE;
        ST_LO_SAMPLE:  state_s = cnt_zero_s ? ST_LO_CONV    : ST_LO_SAMPLE;
        ST_LO_CONV:    state_s = conv_ok_s ? ST_NEXT : (cnt_zero_s ? ST_IDLE : ST_LO_CONV);
        ST_NEXT:       state_s = last_pair_s ? ST_DONE : ST_HI_SETTLE;
        ST_DONE:       state_s = ST_IDLE;
        default:       state_s = ST_IDLE;
      endcase
    end
  end

  // Phase counter: load on entry to a new state, count down while inside it
  always_comb begin
    cnt_s = cnt_r;
    if (state_s != state_r) begin
      case (state_s)
        ST_PC_BOOT:                  cnt_s = phase_load(CTR_W'(p_clk_count_precharge));
        ST_HI_SETTLE, ST_PC_RESTORE: cnt_s = phase_load(CTR_W'(pc_r));
        ST_HI_SAMPLE, ST_LO_SAMPLE:  cnt_s = phase_load(CTR_W'(dur_r));
        ST_HI_CONV, ST_LO_CONV:      cnt_s = TO_LOAD;
        default:                     cnt_s = CTR_ZERO;
      endcase
    end else if (!cnt_zero_s) begin
      cnt_s = cnt_r - CTR_ONE;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Output decode from the upcoming state, so every output leaves a flop
  always_comb begin
    sw_s        = (state_s == ST_HI_SAMPLE) || (state_s == ST_HI_CONV);
    azhi_s      = (state_s == ST_HI_SETTLE) || (state_s == ST_HI_SAMPLE) ||
                  (state_s == ST_HI_CONV)   || (state_s == ST_PC_RESTORE);
    wait_s      = (state_s == ST_HI_CONV) || (state_s == ST_LO_CONV);
    busy_s      = (state_s != ST_IDLE) && (state_s != ST_DONE);
    done_s      = (state_s == ST_DONE);
    adc_start_s = wait_s && (state_s != state_r);
    azmux_s     = azhi_s ? hi_r : (accept_s ? azmux_lo_val : lo_r);
    if (adc_start_s) begin
      phase_hi_s = (state_s == ST_HI_CONV);
    end else begin
      phase_hi_s = phase_hi_r;
    end
    if (accept_s) begin
      error_s = 1'b0;
      idx_s   = {IDX_W{1'b0}};
    end else begin
      error_s = error_r | timeout_s;
      if ((state_r == ST_NEXT) && !abort) begin
        idx_s = idx_inc_s;
      end else begin
        idx_s = sample_idx_r;
      end
    end
  end

  // Run configuration, captured only when a start is accepted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_r    <= {PC_W{1'b0}};
      dur_r   <= {CNT_W{1'b0}};
      count_r <= {IDX_W{1'b0}};
      lo_r    <= azmux_lo_val;
      hi_r    <= azmux_hi_val;
    end else if (accept_s) begin
      pc_r    <= p_clk_count_precharge;
      dur_r   <= p_clk_sample_duration;
      count_r <= p_sample_count;
      lo_r    <= azmux_lo_val;
      hi_r    <= azmux_hi_val;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_pc_r      <= 1'b0;
      azmux_r      <= azmux_lo_val;
      adc_start_r  <= 1'b0;
      phase_hi_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      sample_idx_r <= {IDX_W{1'b0}};
      monitor_r    <= 8'h00;
    end else begin
      sw_pc_r      <= sw_s;
      azmux_r      <= azmux_s;
      adc_start_r  <= adc_start_s;
      phase_hi_r   <= phase_hi_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      error_r      <= error_s;
      sample_idx_r <= idx_s;
      monitor_r    <= {4'b0000, wait_s, adc_start_s, sw_s, azhi_s};
    end
  end

  assign sw_pc_ctl    = sw_pc_r;
  assign azmux        = azmux_r;
  assign adc_start    = adc_start_r;
  assign adc_phase_hi = phase_hi_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign sample_idx   = sample_idx_r;
  assign monitor      = monitor_r;

endmodule
